// File: rtl/cpu_pkg.sv
// cpu_pkg: shared address map and types for the fetch stage.
//   RESET_ADDR   - PC after reset (start of text segment)
//   HANDLER_ADDR - exception/interrupt handler entry
//   IM_BASE      - lowest valid instruction fetch address
//   IM_LAST      - highest valid word-aligned instruction fetch address
package cpu_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t RESET_ADDR   = 32'h0000_3000;
  localparam addr_t HANDLER_ADDR = 32'h0000_4180;
  localparam addr_t IM_BASE      = 32'h0000_3000;
  localparam addr_t IM_LAST      = 32'h0000_6FFC;

endpackage

// File: rtl/pc_range_check.sv
// pc_range_check: purely combinational instruction-fetch address check.
// Flags a PC that is not word aligned or that lies outside the
// instruction memory window [IM_BASE, IM_LAST].
// Ports:
//   pc_q - current PC value (registered upstream)
//   adel - 1 when a fetch from pc_q would raise AdEL
module pc_range_check #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] IM_BASE = WIDTH'(cpu_pkg::IM_BASE),
  parameter logic [WIDTH-1:0] IM_LAST = WIDTH'(cpu_pkg::IM_LAST)
) (
  input  logic [WIDTH-1:0] pc_q,
  output logic             adel
);

  logic misaligned;
  logic below_base;
  logic above_last;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign below_base = (pc_q < IM_BASE);
  assign above_last = (pc_q > IM_LAST);

  assign adel = misaligned | below_base | above_last;

endmodule

// File: rtl/program_counter.sv
// program_counter: fetch-address register of the instruction-fetch unit.
// Each rising edge the PC resets, jumps to the exception handler, loads
// the next-PC value from the NPC logic, or holds while the pipeline stalls.
// Ports:
//   clk  - system clock, all updates on the rising edge
//   res  - synchronous active-high reset (highest priority)
//   Req  - interrupt/exception request from CP0, beats WE
//   WE   - PC write enable; 0 = stall, PC holds
//   pc   - next-PC value, loaded verbatim (no masking or clamping)
//   adel - (only with PC_ALIGN_CHK_EN) fetch address error flag
//   PC   - current PC, driven straight from the register
// Optional feature macro: PC_ALIGN_CHK_EN adds the adel output and the
// pc_range_check instance; it never affects how the PC is updated.
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR   = WIDTH'(cpu_pkg::RESET_ADDR),
  parameter logic [WIDTH-1:0] HANDLER_ADDR = WIDTH'(cpu_pkg::HANDLER_ADDR),
  parameter logic [WIDTH-1:0] IM_BASE      = WIDTH'(cpu_pkg::IM_BASE),
  parameter logic [WIDTH-1:0] IM_LAST      = WIDTH'(cpu_pkg::IM_LAST)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             Req,
  input  logic             WE,
  input  logic [WIDTH-1:0] pc,
`ifdef PC_ALIGN_CHK_EN
  output logic             adel,
`endif
  output logic [WIDTH-1:0] PC
);

  logic [WIDTH-1:0] pc_q;

  // NOTE: non-blocking assignment keeps the register update race-free
  // against any other process sampling pc_q on the same edge.
  // Reset lives inside the clocked block, so it is synchronous; while res
  // is high the Req/WE branches are never evaluated, so X on them cannot
  // reach the register.
  always_ff @(posedge clk) begin
    if (res) begin
      pc_q <= RESET_ADDR;
    end else if (Req) begin
      // A stall must never block exception entry.
      pc_q <= HANDLER_ADDR;
    end else if (WE) begin
      pc_q <= pc;
    end
  end

  assign PC = pc_q;

`ifdef PC_ALIGN_CHK_EN
  pc_range_check #(
    .WIDTH   (WIDTH),
    .IM_BASE (IM_BASE),
    .IM_LAST (IM_LAST)
  ) u_range_check (
    .pc_q (pc_q),
    .adel (adel)
  );
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: self-checking bench for program_counter.
// Directed scenarios followed by randomized traffic, compared against a
// behavioural reference of the PC update priority.
module tb_program_counter;
  import cpu_pkg::*;

  logic  clk;
  logic  res;
  logic  Req;
  logic  WE;
  addr_t pc;
  addr_t PC;
`ifdef PC_ALIGN_CHK_EN
  logic  adel;
`endif

  int total = 0;
  int bad   = 0;

  addr_t exp_pc;

  program_counter dut (
    .clk  (clk),
    .res  (res),
    .Req  (Req),
    .WE   (WE),
    .pc   (pc),
`ifdef PC_ALIGN_CHK_EN
    .adel (adel),
`endif
    .PC   (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Reference: what the PC must become after an edge with these inputs.
  function automatic addr_t next_pc(input addr_t cur, input logic r,
                                    input logic q, input logic w,
                                    input addr_t p);
    if (r)      return 32'h0000_3000;
    else if (q) return 32'h0000_4180;
    else if (w) return p;
    else        return cur;
  endfunction

  function automatic logic exp_adel(input addr_t a);
    return (a % 4 != 0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  // Apply inputs at the falling edge, clock once, check after the edge.
  task automatic step(input string tag, input logic r, input logic q,
                      input logic w, input addr_t p);
    @(negedge clk);
    res = r;
    Req = q;
    WE  = w;
    pc  = p;
    @(posedge clk);
    exp_pc = next_pc(exp_pc, r, q, w, p);
    #1;
    check(tag, PC, exp_pc);
`ifdef PC_ALIGN_CHK_EN
    check({tag, "_adel"}, {31'd0, adel}, {31'd0, exp_adel(exp_pc)});
`endif
  endtask

  initial begin
    res = 1'b1;
    Req = 1'b0;
    WE  = 1'b1;
    pc  = 32'h1234_5678;
    exp_pc = '0;

    // Reset for two cycles; Req on the second must not win, and X on
    // the control inputs must not leak through.
    step("reset1", 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    step("reset2_req", 1'b1, 1'b1, 1'b1, 32'h1234_5678);
    step("reset_x", 1'b1, 1'bx, 1'bx, 32'h1234_5678);

    // Sequential loads.
    step("load_3004", 1'b0, 1'b0, 1'b1, 32'h0000_3004);
    step("load_3008", 1'b0, 1'b0, 1'b1, 32'h0000_3008);
    step("load_4000", 1'b0, 1'b0, 1'b1, 32'h0000_4000);

    // Stall for three cycles, then release.
    step("load_3010", 1'b0, 1'b0, 1'b1, 32'h0000_3010);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 1'b0, 32'h0000_3014);
    step("unstall", 1'b0, 1'b0, 1'b1, 32'h0000_3014);

    // No combinational path from inputs to PC.
    @(negedge clk);
    Req = 1'b1;
    WE  = 1'b1;
    pc  = 32'hDEAD_BEEC;
    #1;
    check("no_comb_path", PC, 32'h0000_3014);
    Req = 1'b0;

    // Exception while stalled, then continue from the handler.
    step("exc_stall", 1'b0, 1'b1, 1'b0, 32'h0000_3020);
    step("after_exc", 1'b0, 1'b0, 1'b1, 32'h0000_4184);

    // Held Req keeps reloading the handler.
    for (int i = 0; i < 3; i++) step("req_held", 1'b0, 1'b1, 1'b1, 32'h0000_5000);

    // Raw loads and range boundaries.
    step("raw_fffe", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step("raw_fffc", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("last_6ffc", 1'b0, 1'b0, 1'b1, 32'h0000_6FFC);
    step("past_7000", 1'b0, 1'b0, 1'b1, 32'h0000_7000);
    step("below_2ffc", 1'b0, 1'b0, 1'b1, 32'h0000_2FFC);

    // Reset mid-run beats concurrent Req and WE.
    step("load_5000", 1'b0, 1'b0, 1'b1, 32'h0000_5000);
    step("reset_mid", 1'b1, 1'b1, 1'b1, 32'h0000_5004);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic  r, q, w;
      addr_t p;
      r = ($urandom_range(0, 31) == 0);
      q = ($urandom_range(0, 7) == 0);
      w = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       p = $urandom;
        1:       p = 32'h0000_2FF0 + ($urandom_range(0, 15) * 4);
        2:       p = 32'h0000_6FF0 + $urandom_range(0, 31);
        default: p = 32'h0000_3000 + ($urandom_range(0, 4095) * 4);
      endcase
      step("random", r, q, w, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 32-bit program-counter register for the instruction-fetch unit of the pipelined MIPS-style CPU.
- Holds the current fetch address. The fetch unit subtracts 0x3000 from it and uses bits [13:2] to index a 4096-word instruction memory.
- Each cycle it loads the next-PC value supplied by the NPC logic, holds it during a stall, or jumps to the exception-handler entry on an interrupt/exception request.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_3000, PC value after reset (start of text segment).
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry address.
- IM_BASE, 32'h0000_3000, lowest valid fetch address (used only by the optional check).
- IM_LAST, 32'h0000_6FFC, highest valid word fetch address (used only by the optional check).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- res, input, 1, synchronous, active-high reset.
- Req, input, 1, interrupt/exception request from CP0; redirects the PC to the handler.
- WE, input, 1, PC write enable; 0 means the pipeline is stalled and the PC holds.
- pc, input, WIDTH, next-PC value from the NPC logic.
- PC, output, WIDTH, current PC value (registered).

Behaviour:
- One register, PC_q. Output PC equals PC_q combinationally; there is no further logic on the output.
- Priority at each rising clk edge:
  1. res=1: PC_q <= RESET_ADDR.
  2. else Req=1: PC_q <= HANDLER_ADDR, regardless of WE. A stall never blocks exception entry.
  3. else WE=1: PC_q <= pc.
  4. else: PC_q holds.
- Reset value of PC is 0x0000_3000. Reset is synchronous only: before the first clock edge with res=1 the value is undefined. Implementations must not use an asynchronous reset.
- Latency: a new pc appears on PC one cycle after the edge at which it is sampled. There is no combinational path from pc, WE or Req to PC.
- The pc input is loaded verbatim: no alignment masking, no range clamping, no wrap handling. 0xFFFF_FFFC loads as-is.
- Req asserted for N consecutive cycles reloads HANDLER_ADDR each cycle; the PC stays at 0x4180 until Req deasserts.
- res asserted mid-operation overrides any concurrent Req or WE in the same cycle.
- X on WE or Req while res=1 must not propagate to PC.

Optional Feature:
- Macro PC_ALIGN_CHK_EN.
- When defined, adds output port adel (1 bit, combinational from PC_q). adel=1 when PC_q[1:0]!=0, or PC_q<IM_BASE, or PC_q>IM_LAST.
- adel is consumed by CP0 as an instruction-fetch AdEL exception. It does not alter PC update logic.
- When undefined, the port and logic are absent and behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams RESET_ADDR=32'h3000, HANDLER_ADDR=32'h4180, IM_BASE=32'h3000, IM_LAST=32'h6FFC;
  - typedef addr_t (logic [31:0]).
- Optional sub-module pc_range_check: a purely combinational PC -> adel block, instantiated only under PC_ALIGN_CHK_EN.

Test Plan:
- Reset: res=1 for 2 cycles with pc=0x1234_5678, WE=1 -> PC=0x0000_3000 after the first edge; Req=1 concurrently still gives 0x3000.
- Sequential load: res=0, WE=1, pc=0x3004, then 0x3008, then 0x4000 -> PC equals each value one cycle later.
- Stall: PC=0x3010, WE=0, pc=0x3014 for 3 cycles -> PC stays 0x3010; WE=1 -> 0x3014 next cycle.
- Exception during stall: WE=0, Req=1, pc=0x3020 -> PC=0x4180 next cycle; Req=0, WE=1, pc=0x4184 -> PC=0x4184.
- Raw load: WE=1, pc=0xFFFF_FFFE -> PC=0xFFFF_FFFE. With PC_ALIGN_CHK_EN, adel=1; pc=0x6FFC gives adel=0; pc=0x7000 gives adel=1.
- Reset mid-run: PC=0x5000, then res=1 with WE=1, Req=1 -> PC=0x3000 next cycle.
